// File: rtl/ram_responder_pkg.sv
// ram_pkg -- shared types for the ram_responder slice.
//   ram_state_e    : clear FSM states (RAM_CLEAR zeroes the array, RAM_RUN serves traffic)
//   RAM_WORD_BYTES : bytes per RAM word (one byte lane per write strobe bit)
//   ram_rd_beat_t  : one read result travelling down the read pipeline
//   ram_addr_err() : true for a misaligned byte address or one beyond the array
package ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_RUN} ram_state_e;

  localparam int RAM_WORD_BYTES = 4;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } ram_rd_beat_t;

  function automatic logic ram_addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) ||
           ({32'b0, addr} >= 64'(depth) * 64'(RAM_WORD_BYTES));
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// ram_responder_if -- memory port between the execution unit and the RAM.
//   ready                         : RAM finished its post-reset clear
//   rd_ram_en/addr                : read request (byte address)
//   rd_ram_data/valid, rd_err     : read response strobe, data, error flag
//   wr_ram_en/addr/data/strb      : byte-strobed write request
//   wr_err                        : one-cycle pulse after a rejected write
// Modports: master = execution unit side, slave = RAM side.
interface ram_responder_if;
  logic        ready;
  logic        rd_ram_en;
  logic [31:0] rd_ram_addr;
  logic [31:0] rd_ram_data;
  logic        rd_ram_valid;
  logic        rd_err;
  logic        wr_ram_en;
  logic [31:0] wr_ram_addr;
  logic [31:0] wr_ram_data;
  logic [3:0]  wr_ram_strb;
  logic        wr_err;

  modport master (
    input  ready, rd_ram_data, rd_ram_valid, rd_err, wr_err,
    output rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data, wr_ram_strb
  );

  modport slave (
    output ready, rd_ram_data, rd_ram_valid, rd_err, wr_err,
    input  rd_ram_en, rd_ram_addr, wr_ram_en, wr_ram_addr, wr_ram_data, wr_ram_strb
  );
endinterface

// File: rtl/ram_responder_read_pipe.sv
// ram_read_pipe -- STAGES-deep delay line for read beats, async-cleared.
//   clk, reset_n : clock, asynchronous active-low reset
//   beat_in      : beat produced by the array read register
//   beat_out     : beat delayed by STAGES edges (STAGES=0: plain wire)
// Data fields only move on a valid beat, so the output data holds the
// last returned word while no read is in flight.
module ram_read_pipe
  import ram_pkg::*;
#(
  parameter int STAGES = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  ram_rd_beat_t beat_in,
  output ram_rd_beat_t beat_out
);

  generate
    if (STAGES == 0) begin : g_pass
      assign beat_out = beat_in;
    end else begin : g_pipe
      ram_rd_beat_t chain [STAGES+1];
      assign chain[0] = beat_in;

      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        ram_rd_beat_t stage_reg;

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            stage_reg <= '0;
          end else begin
            stage_reg.valid <= chain[gi].valid;
            stage_reg.err   <= chain[gi].valid & chain[gi].err;
            if (chain[gi].valid) begin
              stage_reg.data <= chain[gi].data;
            end
          end
        end

        assign chain[gi+1] = stage_reg;
      end

      assign beat_out = chain[STAGES];
    end
  endgenerate

endmodule

// File: rtl/ram_responder.sv
// ram_responder -- word-organised RAM serving the execution unit's memory port.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : ram_responder_if.slave (ready, read port, byte-strobed write port)
// After reset the clear FSM writes zero to every word (DEPTH cycles) and
// only then raises ready; requests arriving before that are ignored.
// Reads return after READ_LATENCY edges with full throughput.
// Build option: define RAM_WRITE_BYPASS_EN to make a same-edge read/write of
// one word return the strobe-merged new word (write-first); otherwise the
// read returns the old word (read-before-write).
module ram_responder
  import ram_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  ram_responder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  ram_state_e    state_reg;
  logic [AW-1:0] clr_cnt_reg;
  logic          wr_err_reg;
  logic          rd_valid_reg;
  logic          rd_err_reg;
  logic [31:0]   rd_word;
  ram_rd_beat_t  beat0;
  ram_rd_beat_t  beat_out;

  logic          running;
  logic          rd_bad;
  logic          wr_bad;
  logic          rd_fire;
  logic          wr_fire;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  assign running = (state_reg == RAM_RUN);
  assign rd_idx  = bus.rd_ram_addr[AW+1:2];
  assign wr_idx  = bus.wr_ram_addr[AW+1:2];
  assign rd_bad  = ram_addr_err(bus.rd_ram_addr, DEPTH);
  assign wr_bad  = ram_addr_err(bus.wr_ram_addr, DEPTH);
  assign rd_fire = running & bus.rd_ram_en;
  assign wr_fire = running & bus.wr_ram_en & ~wr_bad;

`ifdef RAM_WRITE_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = wr_fire & (wr_idx == rd_idx);
`endif

  // Clear FSM and write-error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= RAM_CLEAR;
      clr_cnt_reg <= '0;
      wr_err_reg  <= 1'b0;
    end else begin
      wr_err_reg <= running & bus.wr_ram_en & wr_bad;
      case (state_reg)
        RAM_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == AW'(DEPTH - 1)) begin
            state_reg <= RAM_RUN;
          end
        end
        RAM_RUN:   state_reg <= RAM_RUN;
        default:   state_reg <= RAM_CLEAR;
      endcase
    end
  end

  // One memory per byte lane: a strobe bit maps to a single lane write
  // enable, and the clear sweep drives all lanes at the clear counter.
  for (genvar gi = 0; gi < RAM_WORD_BYTES; gi++) begin : g_lane
    logic [7:0]    lane_mem [DEPTH];
    logic          lane_we;
    logic [AW-1:0] lane_addr;
    logic [7:0]    lane_wdata;
    logic [7:0]    lane_rd;
    logic [7:0]    rd_byte_reg;

    assign lane_we    = ~running | (wr_fire & bus.wr_ram_strb[gi]);
    assign lane_addr  = running ? wr_idx : clr_cnt_reg;
    assign lane_wdata = running ? bus.wr_ram_data[8*gi +: 8] : 8'h00;

    always_ff @(posedge clk) begin
      if (lane_we) begin
        lane_mem[lane_addr] <= lane_wdata;
      end
    end

`ifdef RAM_WRITE_BYPASS_EN
    assign lane_rd = (bypass_hit & bus.wr_ram_strb[gi]) ? bus.wr_ram_data[8*gi +: 8]
                                                        : lane_mem[rd_idx];
`else
    assign lane_rd = lane_mem[rd_idx];
`endif

    // Registered read; holds between reads so idle cycles keep the last data.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_byte_reg <= 8'h00;
      end else if (rd_fire) begin
        rd_byte_reg <= rd_bad ? 8'h00 : lane_rd;
      end
    end

    assign rd_word[8*gi +: 8] = rd_byte_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
      rd_err_reg   <= rd_fire & rd_bad;
    end
  end

  assign beat0.valid = rd_valid_reg;
  assign beat0.err   = rd_err_reg;
  assign beat0.data  = rd_word;

  // The array read register is the first latency stage.
  ram_read_pipe #(
    .STAGES (READ_LATENCY - 1)
  ) u_read_pipe (
    .clk      (clk),
    .reset_n  (reset_n),
    .beat_in  (beat0),
    .beat_out (beat_out)
  );

  assign bus.ready        = running;
  assign bus.rd_ram_valid = beat_out.valid;
  assign bus.rd_err       = beat_out.err;
  assign bus.rd_ram_data  = beat_out.data;
  assign bus.wr_err       = wr_err_reg;

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder -- randomized and directed checks of ram_responder against
// a word-array / pending-read-queue reference model.
module tb_ram_responder;
  import ram_pkg::*;

  localparam int DEPTH = 1024;
  localparam int RL    = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_responder_if bus();

  ram_responder #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] data;
  } pend_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  pend_t       pend_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          clr_left;
  bit          exp_valid, exp_err, exp_wr_err, exp_ready;
  logic [31:0] exp_data;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Advance one clock edge and update the reference model from the requests
  // that were present at that edge; returns #1 after the edge.
  task automatic tick();
    bit          run;
    logic [31:0] rv;
    pend_t       p;
    @(posedge clk);
    cyc++;
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
    exp_wr_err = 1'b0;
    if (reset_n) begin
      run = (clr_left == 0);
      if (run && bus.rd_ram_en) begin
        if (addr_bad(bus.rd_ram_addr)) begin
          rv = 32'h0;
        end else begin
          rv = ref_mem[word_of(bus.rd_ram_addr)];
`ifdef RAM_WRITE_BYPASS_EN
          if (bus.wr_ram_en && !addr_bad(bus.wr_ram_addr) &&
              word_of(bus.wr_ram_addr) == word_of(bus.rd_ram_addr))
            rv = merge(rv, bus.wr_ram_data, bus.wr_ram_strb);
`endif
        end
        p.due  = cyc + RL - 1;
        p.err  = addr_bad(bus.rd_ram_addr);
        p.data = rv;
        pend_q.push_back(p);
        $display("cyc=%0d rd addr=%h", cyc, bus.rd_ram_addr);
      end
      if (run && bus.wr_ram_en) begin
        if (addr_bad(bus.wr_ram_addr)) exp_wr_err = 1'b1;
        else ref_mem[word_of(bus.wr_ram_addr)] =
               merge(ref_mem[word_of(bus.wr_ram_addr)], bus.wr_ram_data, bus.wr_ram_strb);
        $display("cyc=%0d wr addr=%h data=%h strb=%b", cyc, bus.wr_ram_addr,
                 bus.wr_ram_data, bus.wr_ram_strb);
      end
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        p = pend_q.pop_front();
        exp_valid = 1'b1;
        exp_err   = p.err;
        exp_data  = p.data;
      end
      if (clr_left > 0) clr_left--;
    end
    exp_ready = reset_n && (clr_left == 0);
    #1;
  endtask

  task automatic set_rd(input bit en, input logic [31:0] addr);
    bus.rd_ram_en   = en;
    bus.rd_ram_addr = addr;
  endtask

  task automatic set_wr(input bit en, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
    bus.wr_ram_en   = en;
    bus.wr_ram_addr = addr;
    bus.wr_ram_data = data;
    bus.wr_ram_strb = strb;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pend_q.delete();
    clr_left = DEPTH;
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    exp_valid = 0; exp_err = 0; exp_wr_err = 0; exp_ready = 0; exp_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < DEPTH; i++) tick();
  endtask

  task automatic test_reset();
    set_rd(1'b1, 32'h10);
    set_wr(1'b1, 32'h10, 32'h1234_5678, 4'hF);
    do_reset();
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
    checks++; if (bus.rd_ram_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.rd_ram_valid); end
    checks++; if (bus.rd_ram_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.rd_ram_data); end
    checks++; if (bus.rd_err !== 1'b0) begin errors++; $display("FAIL reset_rd_err got=%b exp=0", bus.rd_err); end
    checks++; if (bus.wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got=%b exp=0", bus.wr_err); end
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if (bus.ready !== (i == DEPTH - 1)) begin
        errors++; $display("FAIL clear_ready edge=%0d got=%b exp=%b", i + 1, bus.ready, i == DEPTH - 1);
      end
      checks++;
      if (bus.rd_ram_valid !== 1'b0 || bus.wr_err !== 1'b0) begin
        errors++; $display("FAIL clear_strobe edge=%0d valid=%b wr_err=%b exp=0/0", i + 1, bus.rd_ram_valid, bus.wr_err);
      end
    end
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h10);
    for (int k = 0; k < RL; k++) begin
      tick();
      if (k == 0) set_rd(1'b0, 32'h0);
      checks++;
      if (bus.rd_ram_valid !== (k == RL - 1)) begin
        errors++; $display("FAIL first_read_valid k=%0d got=%b exp=%b", k, bus.rd_ram_valid, k == RL - 1);
      end
    end
    checks++; if (bus.rd_ram_data !== 32'h0 || bus.rd_err !== 1'b0) begin
      errors++; $display("FAIL first_read_data got=%h err=%b exp=00000000 err=0", bus.rd_ram_data, bus.rd_err);
    end
  endtask

  task automatic test_latency();
    int req_cyc, first_valid, n_valid;
    first_valid = -1; n_valid = 0;
    set_wr(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    tick();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h40);
    req_cyc = cyc + 1;
    for (int i = 0; i < 3 + RL + 2; i++) begin
      tick();
      if (i == 2) set_rd(1'b0, 32'h0);
      checks++;
      if (bus.rd_ram_valid !== exp_valid) begin
        errors++; $display("FAIL burst_valid cyc=%0d got=%b exp=%b", cyc, bus.rd_ram_valid, exp_valid);
      end
      if (bus.rd_ram_valid === 1'b1) begin
        n_valid++;
        if (first_valid < 0) first_valid = cyc;
        checks++;
        if (bus.rd_ram_data !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL burst_data cyc=%0d got=%h exp=deadbeef", cyc, bus.rd_ram_data);
        end
      end
    end
    checks++; if (n_valid != 3) begin errors++; $display("FAIL burst_count got=%0d exp=3", n_valid); end
    checks++; if (first_valid != req_cyc + RL - 1) begin
      errors++; $display("FAIL burst_latency got=%0d exp=%0d", first_valid, req_cyc + RL - 1);
    end
  endtask

  task automatic test_strobe();
    set_wr(1'b1, 32'h8, 32'h1122_3344, 4'hF);
    tick();
    set_wr(1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101);
    tick();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h8);
    tick();
    set_rd(1'b0, 32'h0);
    repeat (RL - 1) tick();
    checks++; if (bus.rd_ram_valid !== 1'b1 || bus.rd_ram_data !== 32'h11BB_33DD) begin
      errors++; $display("FAIL strobe_merge valid=%b got=%h exp=11bb33dd", bus.rd_ram_valid, bus.rd_ram_data);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] want1, want2;
`ifdef RAM_WRITE_BYPASS_EN
    want1 = 32'hCAFE_F00D; want2 = 32'hCAFE_7788;
`else
    want1 = 32'h0000_0001; want2 = 32'hCAFE_F00D;
`endif
    set_wr(1'b1, 32'h20, 32'h1, 4'hF);
    tick();
    set_wr(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
    set_rd(1'b1, 32'h20);
    tick();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    repeat (RL - 2) tick();
    checks++; if (bus.rd_ram_valid !== 1'b1 || bus.rd_ram_data !== want1) begin
      errors++; $display("FAIL same_edge valid=%b got=%h exp=%h", bus.rd_ram_valid, bus.rd_ram_data, want1);
    end
    set_wr(1'b1, 32'h20, 32'h5566_7788, 4'b0011);
    set_rd(1'b1, 32'h20);
    tick();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b0, 32'h0);
    repeat (RL - 1) tick();
    checks++; if (bus.rd_ram_valid !== 1'b1 || bus.rd_ram_data !== want2) begin
      errors++; $display("FAIL same_edge_strb valid=%b got=%h exp=%h", bus.rd_ram_valid, bus.rd_ram_data, want2);
    end
    set_rd(1'b1, 32'h20);
    tick();
    set_rd(1'b0, 32'h0);
    repeat (RL - 1) tick();
    checks++; if (bus.rd_ram_data !== 32'hCAFE_7788) begin
      errors++; $display("FAIL after_write got=%h exp=cafe7788", bus.rd_ram_data);
    end
  endtask

  task automatic test_errors();
    logic [31:0] word0;
    int n_wr_err;
    n_wr_err = 0;
    word0 = $urandom;
    set_wr(1'b1, 32'h0, word0, 4'hF);
    tick();
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h6);
    tick();
    set_rd(1'b1, 32'(4 * DEPTH));
    set_wr(1'b1, 32'h2, ~word0, 4'hF);
    tick();
    set_rd(1'b1, 32'h0);
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < RL + 3; i++) begin
      if (i == 1) set_rd(1'b0, 32'h0);
      checks++;
      if (bus.rd_ram_valid !== exp_valid || bus.rd_err !== exp_err || bus.rd_ram_data !== exp_data) begin
        errors++; $display("FAIL err_read cyc=%0d got=%b/%b/%h exp=%b/%b/%h", cyc, bus.rd_ram_valid,
                           bus.rd_err, bus.rd_ram_data, exp_valid, exp_err, exp_data);
      end
      checks++;
      if (bus.wr_err !== exp_wr_err) begin
        errors++; $display("FAIL wr_err cyc=%0d got=%b exp=%b", cyc, bus.wr_err, exp_wr_err);
      end
      if (bus.wr_err === 1'b1) n_wr_err++;
      if (bus.rd_ram_valid === 1'b1 && bus.rd_err === 1'b1) begin
        checks++;
        if (bus.rd_ram_data !== 32'h0) begin
          errors++; $display("FAIL err_data got=%h exp=00000000", bus.rd_ram_data);
        end
      end
      tick();
    end
    checks++; if (n_wr_err != 1) begin errors++; $display("FAIL wr_err_pulses got=%0d exp=1", n_wr_err); end
    checks++; if (bus.rd_ram_data !== word0) begin
      errors++; $display("FAIL word0_kept got=%h exp=%h", bus.rd_ram_data, word0);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra, wa;
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 99) < 85) ? 32'($urandom_range(0, 15)) << 2 :
           (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) | 32'h1 : $urandom | 32'h1000);
      wa = ($urandom_range(0, 99) < 85) ? 32'($urandom_range(0, 15)) << 2 :
           (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) | 32'h2 : $urandom | 32'h1000);
      set_rd(1'($urandom_range(0, 1)), ra);
      set_wr(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)));
      tick();
      checks++;
      if (bus.rd_ram_valid !== exp_valid || bus.rd_err !== exp_err || bus.rd_ram_data !== exp_data) begin
        errors++; $display("FAIL rand_read cyc=%0d got=%b/%b/%h exp=%b/%b/%h", cyc, bus.rd_ram_valid,
                           bus.rd_err, bus.rd_ram_data, exp_valid, exp_err, exp_data);
      end
      checks++;
      if (bus.wr_err !== exp_wr_err || bus.ready !== exp_ready) begin
        errors++; $display("FAIL rand_ctrl cyc=%0d wr_err=%b ready=%b exp=%b/%b", cyc, bus.wr_err,
                           bus.ready, exp_wr_err, exp_ready);
      end
    end
    set_rd(1'b0, 32'h0);
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    repeat (RL + 1) tick();
  endtask

  task automatic test_reset_mid_clear();
    int n_valid;
    n_valid = 0;
    do_reset();
    repeat (500) tick();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if (bus.ready !== (i == DEPTH - 1)) begin
        errors++; $display("FAIL restart_ready edge=%0d got=%b exp=%b", i + 1, bus.ready, i == DEPTH - 1);
      end
    end
    set_rd(1'b1, 32'h40);
    tick();
    set_rd(1'b0, 32'h0);
    do_reset();
    for (int i = 0; i < DEPTH + RL + 2; i++) begin
      tick();
      if (bus.rd_ram_valid === 1'b1) n_valid++;
    end
    checks++; if (n_valid != 0) begin errors++; $display("FAIL dropped_read valids=%0d exp=0", n_valid); end
    set_rd(1'b1, 32'h40);
    tick();
    set_rd(1'b0, 32'h0);
    repeat (RL - 1) tick();
    checks++; if (bus.rd_ram_valid !== 1'b1 || bus.rd_ram_data !== 32'h0) begin
      errors++; $display("FAIL cleared_word valid=%b got=%h exp=00000000", bus.rd_ram_valid, bus.rd_ram_data);
    end
  endtask

  initial begin
    set_rd(1'b0, 32'h0);
    set_wr(1'b0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_latency();
    test_strobe();
    test_same_edge();
    test_errors();
    test_random();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
